// File: rtl/touch_pkg.sv
// Shared constants, state encoding and point record for the touch frame sequencer.
package touch_pkg;

   localparam int unsigned SETTLE_CYCLES_DEF = 50000;
   localparam int unsigned SPLIT_X_DEF       = 400;
   localparam int unsigned MAX_POINTS        = 5;
   localparam int unsigned X_W               = 10;
   localparam int unsigned Y_W               = 9;
   localparam int unsigned SEL_W             = 3;
   localparam int unsigned COUNT_W           = 4;
   localparam int unsigned FRAME_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_SCAN    = 2'd2,
      ST_PUBLISH = 2'd3
   } state_t;

   typedef struct packed {
      logic           valid;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } point_t;

   // Number of points worth looking at: the reader may report more than the mux holds.
   function automatic logic [SEL_W-1:0] clamp_count(input logic [COUNT_W-1:0] n);
      return (n > COUNT_W'(MAX_POINTS)) ? SEL_W'(MAX_POINTS) : n[SEL_W-1:0];
   endfunction

endpackage

// File: rtl/intn_sync_edge.sv
// Two-flop synchroniser for the touch interrupt plus falling-edge detector.
module intn_sync_edge
   import touch_pkg::*;
(
   input  logic clock,
   input  logic resetn,
   input  logic intn,
   output logic fall_c
);

   logic meta;
   logic sync;
   logic sync_d;

   // Idle level of intn is high, so all flops reset to 1 to avoid a spurious edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         meta   <= intn;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign fall_c = sync_d & ~sync;

endmodule

// File: rtl/touch_frame_sequencer.sv
// Settles after a touch interrupt, scans up to five points into per-half shadows,
// then publishes one frame with valid/ack handshake and sticky overrun.
module touch_frame_sequencer
   import touch_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned SPLIT_X       = SPLIT_X_DEF
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               intn,
   input  logic [COUNT_W-1:0] touch_count,
   output logic [SEL_W-1:0]   pt_sel,
   input  logic [X_W-1:0]     pt_x,
   input  logic [Y_W-1:0]     pt_y,
   output logic [X_W-1:0]     left_x,
   output logic [X_W-1:0]     right_x,
   output logic [Y_W-1:0]     left_y,
   output logic [Y_W-1:0]     right_y,
   output logic               left_valid,
   output logic               right_valid,
   output logic               out_valid,
   input  logic               out_ack,
   output logic               overrun,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned          CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(MAX_POINTS - 1);

   state_t             state;
   state_t             state_next;
   logic               fall_c;
   logic [CNT_W-1:0]   settle_cnt;
   logic [SEL_W-1:0]   scan_lim;
   point_t             sh_left;
   point_t             sh_right;

   logic               settle_clr_c;
   logic               settle_inc_c;
   logic               scan_c;
   logic               publish_c;
   logic               first_c;
   logic [SEL_W-1:0]   lim_c;
   logic               consider_c;
   logic               is_left_c;

   intn_sync_edge u_sync (
      .clock  (clock),
      .resetn (resetn),
      .intn   (intn),
      .fall_c (fall_c)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_next;
   end

   // An edge in SETTLE restarts the wait; edges in SCAN/PUBLISH are dropped.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (fall_c) state_next = ST_SETTLE;
         ST_SETTLE:  if (!fall_c && settle_cnt == CNT_LAST) state_next = ST_SCAN;
         ST_SCAN:    if (pt_sel == SEL_LAST) state_next = ST_PUBLISH;
         ST_PUBLISH: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      settle_clr_c = 1'b0;
      settle_inc_c = 1'b0;
      scan_c       = 1'b0;
      publish_c    = 1'b0;
      case (state)
         ST_IDLE:    settle_clr_c = fall_c;
         ST_SETTLE:  begin
            settle_clr_c = fall_c;
            settle_inc_c = ~fall_c;
         end
         ST_SCAN:    scan_c    = 1'b1;
         ST_PUBLISH: publish_c = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)           settle_cnt <= '0;
      else if (settle_clr_c) settle_cnt <= '0;
      else if (settle_inc_c) settle_cnt <= settle_cnt + CNT_W'(1);
   end

   // pt_sel doubles as the scan index; it is only non-zero inside SCAN.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                          pt_sel <= '0;
      else if (scan_c && pt_sel != SEL_LAST) pt_sel <= pt_sel + SEL_W'(1);
      else                                  pt_sel <= '0;
   end

   assign first_c    = scan_c && (pt_sel == '0);
   assign lim_c      = first_c ? clamp_count(touch_count) : scan_lim;
   assign consider_c = scan_c && (pt_sel < lim_c);
   assign is_left_c  = pt_x < X_W'(SPLIT_X);

   // First considered point of each half wins; the first SCAN cycle clears stale hits.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         scan_lim <= '0;
         sh_left  <= '0;
         sh_right <= '0;
      end else begin
         if (first_c) begin
            scan_lim       <= clamp_count(touch_count);
            sh_left.valid  <= 1'b0;
            sh_right.valid <= 1'b0;
         end
         if (consider_c && is_left_c && (first_c || !sh_left.valid))
            sh_left <= '{valid: 1'b1, x: pt_x, y: pt_y};
         if (consider_c && !is_left_c && (first_c || !sh_right.valid))
            sh_right <= '{valid: 1'b1, x: pt_x, y: pt_y};
      end
   end

   // Publish beats a same-cycle ack; a half with no touch keeps its last coordinates.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         left_x      <= '0;
         left_y      <= '0;
         right_x     <= '0;
         right_y     <= '0;
         left_valid  <= 1'b0;
         right_valid <= 1'b0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
         frame_cnt   <= '0;
      end else if (publish_c) begin
         left_valid  <= sh_left.valid;
         right_valid <= sh_right.valid;
         if (sh_left.valid) begin
            left_x <= sh_left.x;
            left_y <= sh_left.y;
         end
         if (sh_right.valid) begin
            right_x <= sh_right.x;
            right_y <= sh_right.y;
         end
         out_valid <= 1'b1;
         overrun   <= out_ack ? 1'b0 : (overrun | out_valid);
         frame_cnt <= frame_cnt + FRAME_W'(1);
      end else if (out_valid && out_ack) begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_touch_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames from a point-list model, a monitor checks publishes.
module tb_touch_frame_sequencer;

   localparam int SETTLE = 8;
   localparam int SPLIT  = 400;
   // drive -> publish visible: 2 sync flops, 1 cycle into SETTLE, SETTLE, 5 scan, 1 publish
   localparam int PUB_LAT  = 2 + 1 + SETTLE + 5 + 1;
   localparam int SCAN_LAT = 2 + 1 + SETTLE;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       intn = 1'b1;
   logic [3:0] touch_count = 4'd0;
   logic [2:0] pt_sel;
   logic [9:0] pt_x;
   logic [8:0] pt_y;
   logic [9:0] left_x, right_x;
   logic [8:0] left_y, right_y;
   logic       left_valid, right_valid, out_valid, overrun;
   logic       out_ack = 1'b0;
   logic [7:0] frame_cnt;

   logic [9:0] px [5];
   logic [8:0] py [5];

   assign pt_x = (pt_sel < 3'd5) ? px[pt_sel] : 10'd0;
   assign pt_y = (pt_sel < 3'd5) ? py[pt_sel] : 9'd0;

   touch_frame_sequencer #(.SETTLE_CYCLES(SETTLE), .SPLIT_X(SPLIT)) dut (
      .clock(clock), .resetn(resetn), .intn(intn), .touch_count(touch_count),
      .pt_sel(pt_sel), .pt_x(pt_x), .pt_y(pt_y),
      .left_x(left_x), .right_x(right_x), .left_y(left_y), .right_y(right_y),
      .left_valid(left_valid), .right_valid(right_valid),
      .out_valid(out_valid), .out_ack(out_ack), .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit lv; int lx; int ly;
      bit rv; int rx; int ry;
      bit ov; bit ovr; int cnt; int at;
   } exp_t;
   exp_t q[$];

   // published state as the model sees it
   bit m_lv, m_rv, m_ov, m_ovr;
   int m_lx, m_ly, m_rx, m_ry, m_cnt;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   logic [7:0] last_cnt = 8'd0;
   always @(negedge clock) begin
      if (!resetn) begin
         last_cnt <= 8'd0;
      end else if (frame_cnt != last_cnt) begin
         last_cnt <= frame_cnt;
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_publish: frame_cnt %0d with nothing expected", frame_cnt);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pub_cycle",   cyc,         e.at);
            check("left_valid",  left_valid,  e.lv);
            check("left_x",      left_x,      e.lx);
            check("left_y",      left_y,      e.ly);
            check("right_valid", right_valid, e.rv);
            check("right_x",     right_x,     e.rx);
            check("right_y",     right_y,     e.ry);
            check("out_valid",   out_valid,   e.ov);
            check("overrun",     overrun,     e.ovr);
            check("frame_cnt",   frame_cnt,   e.cnt);
         end
      end
   end

   // ack_mode: 0 none, 1 ack in the PUBLISH cycle, 2 ack two cycles after publish
   task automatic do_frame(input int tc, input int ack_mode, input bit restart);
      int   n0, base, lim;
      exp_t e;
      logic [19:0] hold_l, hold_r;
      n0   = cyc;
      base = restart ? n0 + 6 : n0;
      hold_l = {left_valid, left_x, left_y};
      hold_r = {right_valid, right_x, right_y};

      lim = (tc > 5) ? 5 : tc;
      e.lv = 0; e.rv = 0;
      e.lx = m_lx; e.ly = m_ly; e.rx = m_rx; e.ry = m_ry;
      for (int i = 0; i < lim; i++) begin
         if (int'(px[i]) < SPLIT) begin
            if (!e.lv) begin e.lv = 1; e.lx = px[i]; e.ly = py[i]; end
         end else begin
            if (!e.rv) begin e.rv = 1; e.rx = px[i]; e.ry = py[i]; end
         end
      end
      e.ov  = 1;
      e.ovr = (ack_mode == 1) ? 0 : (m_ov ? 1 : m_ovr);
      e.cnt = (m_cnt + 1) % 256;
      e.at  = base + PUB_LAT;
      m_lv = e.lv; m_rv = e.rv; m_lx = e.lx; m_ly = e.ly; m_rx = e.rx; m_ry = e.ry;
      m_ov = e.ov; m_ovr = e.ovr; m_cnt = e.cnt;
      q.push_back(e);

      touch_count = 4'(tc);
      intn = 1'b0;
      wait_until(n0 + 3);
      intn = 1'b1;
      if (restart) begin
         wait_until(n0 + 6);
         intn = 1'b0;
         wait_until(n0 + 9);
         intn = 1'b1;
         wait_until(n0 + 12);
         check("no_early_scan", pt_sel, 0);
      end
      wait_until(base + SCAN_LAT - 1);
      check("sel_settle", pt_sel, 0);
      wait_until(base + SCAN_LAT + 1);
      check("sel_scan1", pt_sel, 1);
      touch_count = 4'($urandom_range(15));
      wait_until(base + SCAN_LAT + 4);
      check("sel_scan4", pt_sel, 4);
      tick();
      check("sel_publish", pt_sel, 0);
      check("held_left", int'(hold_l), int'({left_valid, left_x, left_y}));
      check("held_right", int'(hold_r), int'({right_valid, right_x, right_y}));
      if (ack_mode == 1) out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      if (ack_mode == 2) begin
         tick();
         out_ack = 1'b1;
         tick();
         out_ack = 1'b0;
         m_ov = 0; m_ovr = 0;
         check("ack_clr_valid", out_valid, 0);
         check("ack_clr_overrun", overrun, 0);
      end else begin
         tick();
         tick();
      end
   endtask

   task automatic set_pt(input int i, input int x, input int y);
      px[i] = 10'(x);
      py[i] = 9'(y);
   endtask

   task automatic rand_pts();
      for (int i = 0; i < 5; i++) begin
         int x;
         case ($urandom_range(3))
            0:       x = SPLIT - 1;
            1:       x = SPLIT;
            default: x = $urandom_range(799);
         endcase
         set_pt(i, x, $urandom_range(1, 479));
      end
   endtask

   task automatic reset_mid_scan();
      int n0;
      n0 = cyc;
      rand_pts();
      touch_count = 4'd5;
      intn = 1'b0;
      wait_until(n0 + 3);
      intn = 1'b1;
      wait_until(n0 + SCAN_LAT + 2);
      resetn = 1'b0;
      #1;
      check("rst_pt_sel", pt_sel, 0);
      check("rst_left", int'({left_valid, left_x, left_y}), 0);
      check("rst_right", int'({right_valid, right_x, right_y}), 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      m_lv = 0; m_rv = 0; m_ov = 0; m_ovr = 0;
      m_lx = 0; m_ly = 0; m_rx = 0; m_ry = 0; m_cnt = 0;
      tick();
      tick();
      resetn = 1'b1;
      repeat (SCAN_LAT + 10) tick();
      check("abort_no_valid", out_valid, 0);
      check("abort_no_cnt", frame_cnt, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 5; i++) set_pt(i, 0, 0);
      m_lv = 0; m_rv = 0; m_ov = 0; m_ovr = 0;
      m_lx = 0; m_ly = 0; m_rx = 0; m_ry = 0; m_cnt = 0;
      tick();
      tick();
      check("reset_pt_sel", pt_sel, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      check("reset_left", int'({left_valid, left_x, left_y}), 0);
      resetn = 1'b1;
      repeat (3) tick();

      // single left touch
      set_pt(0, 100, 50); set_pt(1, 700, 300); set_pt(2, 20, 20); set_pt(3, 600, 1); set_pt(4, 5, 5);
      do_frame(1, 0, 0);
      // per-half winners, acked after publish
      set_pt(0, 500, 10); set_pt(1, 450, 20); set_pt(2, 30, 40); set_pt(3, 10, 99); set_pt(4, 790, 77);
      do_frame(3, 2, 0);
      // no touches: coordinates hold
      set_pt(0, 11, 22); set_pt(1, 633, 44); set_pt(2, 1, 1); set_pt(3, 2, 2); set_pt(4, 3, 3);
      do_frame(0, 0, 0);
      // settle restart
      rand_pts();
      do_frame(2, 0, 1);
      // ack in the PUBLISH cycle
      rand_pts();
      do_frame(4, 1, 0);
      // more than five touches reported, both halves present
      set_pt(0, 399, 7); set_pt(1, 400, 8); set_pt(2, 0, 9); set_pt(3, 799, 10); set_pt(4, 200, 11);
      do_frame(9, 0, 0);

      reset_mid_scan();

      for (int i = 0; i < 256; i++) begin
         rand_pts();
         do_frame($urandom_range(15), $urandom_range(2), (i % 8) == 7);
         repeat ($urandom_range(3)) tick();
      end
      check("cnt_wrap", frame_cnt, 0);
      repeat (4) tick();
      check("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/touch_frame_sequencer.md
TOUCH_FRAME_SEQUENCER -- requirements
Module: touch_frame_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 50000, wait in cycles after a touch interrupt before sampling (1 ms at 50 MHz).
REQ-002 SHALL have parameter SPLIT_X, default 400, x boundary between left and right player halves.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port intn  input  1  touch controller interrupt, asynchronous, active-low.
REQ-006 SHALL have port touch_count  input  4  number of touches reported by the touch reader.
REQ-007 SHALL have port pt_sel  output  3  point index (0..4) driven to the external point mux.
REQ-008 SHALL have port pt_x  input  10  x of the selected point, valid in the same cycle as pt_sel.
REQ-009 SHALL have port pt_y  input  9  y of the selected point, valid in the same cycle as pt_sel.
REQ-010 SHALL have ports left_x/right_x  output  10 each  published paddle x per half.
REQ-011 SHALL have ports left_y/right_y  output  9 each  published paddle y per half.
REQ-012 SHALL have ports left_valid/right_valid  output  1 each  touch present in that half in the published frame.
REQ-013 SHALL have port out_valid  output  1  published frame unconsumed.
REQ-014 SHALL have port out_ack  input  1  consumer acknowledge.
REQ-015 SHALL have port overrun  output  1  sticky: a frame was published over an unacknowledged one.
REQ-016 SHALL have port frame_cnt  output  8  count of published frames.

Function
REQ-017 SHALL synchronise intn with two flops and detect a falling edge on the synchronised signal (edge-detect cycle).
REQ-018 SHALL implement FSM states IDLE, SETTLE, SCAN, PUBLISH; reset state IDLE.
REQ-019 IDLE -> SETTLE on an edge-detect cycle; settle counter loads 0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SCAN; a further edge detected in SETTLE restarts the count at 0.
REQ-021 SCAN SHALL last exactly 5 cycles with pt_sel = 0,1,2,3,4 in order; pt_sel = 0 outside SCAN.
REQ-022 In SCAN, point i SHALL be considered only if i < min(touch_count,5); touch_count is sampled on the first SCAN cycle.
REQ-023 A considered point with pt_x < SPLIT_X SHALL belong to the left half, otherwise to the right; the lowest-index point per half wins and later ones are ignored.
REQ-024 Scan results SHALL accumulate in shadow registers; published outputs SHALL NOT change during SETTLE or SCAN.
REQ-025 PUBLISH SHALL last one cycle, then return to IDLE; edges detected in PUBLISH SHALL be ignored.
REQ-026 On the clock edge ending PUBLISH, the shadow registers SHALL copy to the left/right outputs, out_valid SHALL be set, and frame_cnt SHALL increment modulo 256.
REQ-027 A half with no touch SHALL publish valid=0 and hold its previous x/y.
REQ-028 If out_valid=1 and out_ack=0 in the PUBLISH cycle, overrun SHALL be set.
REQ-029 out_ack=1 while out_valid=1 SHALL clear out_valid and overrun on the next edge; out_ack while out_valid=0 has no effect.
REQ-030 If out_ack=1 in the PUBLISH cycle, the publish SHALL win: out_valid stays 1, overrun is cleared and not set.
REQ-031 An edge detected in SCAN SHALL be ignored.

Reset
REQ-032 Asserting resetn low SHALL asynchronously force: FSM IDLE, counters 0, synchroniser flops 1, shadow registers 0, pt_sel 0, all x/y 0, left_valid/right_valid/out_valid/overrun 0, frame_cnt 0.
REQ-033 Reset during SETTLE or SCAN SHALL abort the frame with no publish; after release the block waits for a new falling edge.

Structure
REQ-034 SETTLE_CYCLES default, SPLIT_X, MAX_POINTS=5, coordinate widths (10/9), and the FSM state encoding SHALL live in shared package touch_pkg.
REQ-035 The synchroniser and falling-edge detector SHALL be sub-module intn_sync_edge; the FSM, scan and publish logic SHALL stay in the top.

Verification (SETTLE_CYCLES=8)
REQ-036 Left-half classification: intn pulse low, touch_count=1, pt0=(100,50) -> pt_sel 0..4 starts exactly 8 cycles after the edge-detect cycle; then left=(100,50), left_valid=1, right_valid=0, out_valid=1, frame_cnt=1.
REQ-037 Per-half winner selection: touch_count=3, points (500,10),(450,20),(30,40) -> right=(500,10), left=(30,40), both valid.
REQ-038 touch_count gating: touch_count=0 with nonzero pt data -> both valid=0; x/y keep prior values; frame_cnt increments.
REQ-039 Settle restart: second intn edge 5 cycles into SETTLE -> SCAN starts 8 cycles after the second edge; exactly one publish.
REQ-040 Overrun: two frames without ack -> overrun=1 after the second frame; out_ack -> out_valid=0, overrun=0; ack in the PUBLISH cycle -> out_valid=1, overrun=0.
REQ-041 Reset during SCAN, then frame_cnt wrap: reset mid-SCAN -> all outputs 0, no publish; 256 frames -> frame_cnt returns to 0.
